// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains the read port of a FIFO18_36-style FIFO (fixed read latency) and
//   presents the words as a valid/ready stream. Reads are issued against a
//   credit (buffer occupancy + reads in flight) so the skid buffer can never
//   overflow, and a read is never issued while the FIFO reports empty.
//
// Parameters
//   WIDTH         data width of fifo_data / m_data
//   READ_LATENCY  FIFO read latency, 1 or 2 (2 = FIFO output register on)
//
// Ports
//   clk          read-domain clock
//   rst          synchronous, active-high reset
//   fifo_data    FIFO read data, valid READ_LATENCY cycles after fifo_rden
//   fifo_empty   FIFO empty flag
//   fifo_rderr   FIFO read-error flag (only used with FIFO_READER_ERRCNT_EN)
//   fifo_rden    FIFO read enable
//   m_data       stream data (head of skid buffer)
//   m_valid      stream valid
//   m_ready      stream ready
//   level        skid-buffer occupancy, 0..DEPTH (excludes reads in flight)
//   err_count    saturating count of fifo_rderr cycles
//                (present only when FIFO_READER_ERRCNT_EN is defined)
//
// Build option
//   FIFO_READER_ERRCNT_EN  adds the err_count output.

module fifo_stream_reader #(
   parameter int WIDTH        = 36,
   parameter int READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   input  logic             fifo_rderr,
   output logic             fifo_rden,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [2:0]       level
`ifdef FIFO_READER_ERRCNT_EN
   ,
   output logic [15:0]      err_count
`endif
);

   localparam int unsigned DEPTH = READ_LATENCY + 2;
   localparam int unsigned PTR_W = 2;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [2:0]       DEPTH_L  = 3'(DEPTH);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("fifo_stream_reader: READ_LATENCY must be 1 or 2");
   end

   logic [READ_LATENCY-1:0] pipe;       // one bit per read in flight
   logic [WIDTH-1:0]        mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [2:0]              occ;
   logic [2:0]              credit;     // occ + reads in flight
   logic                    arrive;
   logic                    pop;

   assign arrive    = pipe[READ_LATENCY-1];
   assign m_valid   = (occ != 3'd0);
   assign m_data    = mem[rd_ptr];
   assign level     = occ;
   assign pop       = m_valid && m_ready;
   // m_ready deliberately stays out of this path; a pop frees credit only
   // from the next cycle on.
   assign fifo_rden = !rst && !fifo_empty && (credit < DEPTH_L);

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         credit <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         pipe   <= (pipe << 1) | READ_LATENCY'(fifo_rden);
         occ    <= occ + {2'b00, arrive} - {2'b00, pop};
         credit <= credit + {2'b00, fifo_rden} - {2'b00, pop};
         if (arrive) begin
            mem[wr_ptr] <= fifo_data;
            wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         assert (occ <= DEPTH_L && credit <= DEPTH_L);
      end
   end

`ifdef FIFO_READER_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (fifo_rderr && (err_count != '1)) begin
         err_count <= err_count + 16'd1;
      end
   end
`else
   logic unused_rderr;
   assign unused_rderr = fifo_rderr;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: one instance with READ_LATENCY=1 (a) and one
// with READ_LATENCY=2 (b), each fed by a small behavioural FIFO model.

module tb_fifo_stream_reader;

   localparam int W = 36;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_a, fe_a, rderr_a, rden_a, mv_a, mr_a;
   logic [W-1:0] fd_a, md_a;
   logic [2:0]   lvl_a;
   logic         rst_b, fe_b, rderr_b, rden_b, mv_b, mr_b;
   logic [W-1:0] fd_b, md_b;
   logic [2:0]   lvl_b;
`ifdef FIFO_READER_ERRCNT_EN
   logic [15:0]  ec_a, ec_b;
`endif

   fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(1)) u_dut_a (
      .clk(clk), .rst(rst_a), .fifo_data(fd_a), .fifo_empty(fe_a),
      .fifo_rderr(rderr_a), .fifo_rden(rden_a), .m_data(md_a),
      .m_valid(mv_a), .m_ready(mr_a), .level(lvl_a)
`ifdef FIFO_READER_ERRCNT_EN
      , .err_count(ec_a)
`endif
   );

   fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(2)) u_dut_b (
      .clk(clk), .rst(rst_b), .fifo_data(fd_b), .fifo_empty(fe_b),
      .fifo_rderr(rderr_b), .fifo_rden(rden_b), .m_data(md_b),
      .m_valid(mv_b), .m_ready(mr_b), .level(lvl_b)
`ifdef FIFO_READER_ERRCNT_EN
      , .err_count(ec_b)
`endif
   );

   // FIFO models
   logic [W-1:0] q_a[$];
   logic [W-1:0] q_b[$];
   logic [W-1:0] s1_a, s1_b, s2_b;
   logic         hold_a, hold_b;

   // per-cycle samples (taken at the falling edge)
   logic         s_rden_a, s_valid_a, s_ready_a, s_empty_a;
   logic [W-1:0] s_data_a;
   logic [2:0]   s_level_a;
   logic         s_rden_b, s_valid_b, s_ready_b;
   logic [W-1:0] s_data_b;
   logic [2:0]   s_level_b;

   int total = 0;
   int bad   = 0;

   task automatic upd_empty();
      fe_a = (q_a.size() == 0) || hold_a;
      fe_b = (q_b.size() == 0) || hold_b;
   endtask

   // One clock cycle: sample outputs mid-cycle, then advance the FIFO models.
   task automatic cycle();
      @(negedge clk);
      s_rden_a = rden_a; s_valid_a = mv_a; s_ready_a = mr_a;
      s_data_a = md_a;   s_level_a = lvl_a; s_empty_a = fe_a;
      s_rden_b = rden_b; s_valid_b = mv_b; s_ready_b = mr_b;
      s_data_b = md_b;   s_level_b = lvl_b;
      @(posedge clk);
      #1;
      if (s_rden_a && q_a.size() > 0) s1_a = q_a.pop_front();
      fd_a = s1_a;
      s2_b = s1_b;
      if (s_rden_b && q_b.size() > 0) s1_b = q_b.pop_front();
      fd_b = s2_b;
      upd_empty();
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; mr_a = 1'b1; mr_b = 1'b0;
      for (int i = 0; i < 8; i++)  q_a.push_back(W'(i));
      for (int i = 0; i < 10; i++) q_b.push_back(W'(i));
      upd_empty();
      repeat (3) cycle();
      total++; if (s_rden_a !== 1'b0) begin bad++; $display("FAIL reset_rden_a: got %b want 0", s_rden_a); end
      total++; if (s_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a: got %b want 0", s_valid_a); end
      total++; if (s_level_a !== 3'd0) begin bad++; $display("FAIL reset_level_a: got %0d want 0", s_level_a); end
      total++; if (s_data_a !== '0) begin bad++; $display("FAIL reset_data_a: got %0h want 0", s_data_a); end
      total++; if (s_rden_b !== 1'b0) begin bad++; $display("FAIL reset_rden_b: got %b want 0", s_rden_b); end
      total++; if (s_valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b: got %b want 0", s_valid_b); end
      total++; if (s_level_b !== 3'd0) begin bad++; $display("FAIL reset_level_b: got %0d want 0", s_level_b); end
      total++; if (s_data_b !== '0) begin bad++; $display("FAIL reset_data_b: got %0h want 0", s_data_b); end
`ifdef FIFO_READER_ERRCNT_EN
      total++; if (ec_a !== 16'd0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", ec_a); end
`endif
   endtask

   task automatic test_stream_rl1();
      int  exp_n = 0;
      logic e_rden, e_valid;
      rst_a = 1'b0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         e_rden  = (c <= 7);
         e_valid = (c >= 2 && c <= 9);
         total++; if (s_rden_a !== e_rden) begin bad++; $display("FAIL rl1_rden c=%0d: got %b want %b", c, s_rden_a, e_rden); end
         total++; if (s_valid_a !== e_valid) begin bad++; $display("FAIL rl1_valid c=%0d: got %b want %b", c, s_valid_a, e_valid); end
         if (s_valid_a && s_ready_a) begin
            total++; if (s_data_a !== W'(exp_n)) begin bad++; $display("FAIL rl1_data c=%0d: got %0h want %0h", c, s_data_a, exp_n); end
            exp_n++;
         end
      end
      total++; if (exp_n != 8) begin bad++; $display("FAIL rl1_count: got %0d want 8", exp_n); end
   endtask

   task automatic test_backpressure_rl2();
      int pulses = 0;
      int exp_n = 0;
      int first = -1;
      int last = -1;
      rst_b = 1'b0; mr_b = 1'b0;
      for (int c = 0; c < 8; c++) begin
         cycle();
         pulses += int'(s_rden_b);
      end
      total++; if (pulses != 4) begin bad++; $display("FAIL bp_pulses: got %0d want 4", pulses); end
      total++; if (s_level_b !== 3'd4) begin bad++; $display("FAIL bp_level: got %0d want 4", s_level_b); end
      total++; if (s_rden_b !== 1'b0) begin bad++; $display("FAIL bp_rden_halt: got %b want 0", s_rden_b); end
      total++; if (s_valid_b !== 1'b1 || s_data_b !== W'(0)) begin bad++; $display("FAIL bp_head: got v=%b d=%0h want v=1 d=0", s_valid_b, s_data_b); end
      mr_b = 1'b1;
      for (int c = 0; c < 20; c++) begin
         cycle();
         if (s_valid_b && s_ready_b) begin
            total++; if (s_data_b !== W'(exp_n)) begin bad++; $display("FAIL bp_data c=%0d: got %0h want %0h", c, s_data_b, exp_n); end
            if (first < 0) first = c;
            last = c;
            exp_n++;
         end
      end
      total++; if (exp_n != 10) begin bad++; $display("FAIL bp_count: got %0d want 10", exp_n); end
      total++; if (last - first != 9) begin bad++; $display("FAIL bp_rate: got span %0d want 9", last - first); end
   endtask

   task automatic test_empty_inflight();
      int pulses = 0;
      int got = 0;
      q_b.push_back(36'h100);
      q_b.push_back(36'h101);
      upd_empty();
      mr_b = 1'b1;
      cycle();
      total++; if (s_rden_b !== 1'b1) begin bad++; $display("FAIL ei_first_rden: got %b want 1", s_rden_b); end
      hold_b = 1'b1;
      upd_empty();
      for (int c = 0; c < 8; c++) begin
         cycle();
         pulses += int'(s_rden_b);
         if (s_valid_b && s_ready_b) begin
            total++; if (s_data_b !== 36'h100) begin bad++; $display("FAIL ei_data: got %0h want 100", s_data_b); end
            got++;
         end
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL ei_extra_rden: got %0d want 0", pulses); end
      total++; if (got != 1) begin bad++; $display("FAIL ei_delivered: got %0d want 1", got); end
      total++; if (s_level_b !== 3'd0) begin bad++; $display("FAIL ei_level: got %0d want 0", s_level_b); end
      hold_b = 1'b0;
      q_b.delete();
      upd_empty();
   endtask

   task automatic test_reset_mid();
      mr_b = 1'b0;
      for (int i = 0; i < 4; i++) q_b.push_back(36'h200 + W'(i));
      upd_empty();
      repeat (5) cycle();
      rst_b = 1'b1;
      cycle();
      total++; if (s_level_b !== 3'd3) begin bad++; $display("FAIL rm_pre_level: got %0d want 3", s_level_b); end
      rst_b = 1'b0;
      q_b.delete();
      upd_empty();
      mr_b = 1'b1;
      cycle();
      total++; if (s_valid_b !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", s_valid_b); end
      total++; if (s_level_b !== 3'd0) begin bad++; $display("FAIL rm_level: got %0d want 0", s_level_b); end
      total++; if (s_rden_b !== 1'b0) begin bad++; $display("FAIL rm_rden: got %b want 0", s_rden_b); end
      for (int c = 0; c < 6; c++) begin
         cycle();
         total++; if (s_valid_b !== 1'b0) begin bad++; $display("FAIL rm_ghost c=%0d: got data %0h", c, s_data_b); end
      end
   endtask

   task automatic test_random();
      int pushed = 0;
      int exp_n = 0;
      int budget = 0;
      logic pv = 1'b0;
      logic pr = 1'b0;
      logic [W-1:0] pd = '0;
      while (exp_n < 1000 && budget < 20000) begin
         if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
            q_a.push_back({4'h5, 32'(pushed)});
            pushed++;
         end
         hold_a = ($urandom_range(0, 3) == 0);
         mr_a   = 1'($urandom_range(0, 1));
         upd_empty();
         cycle();
         budget++;
         total++; if (s_rden_a && s_empty_a) begin bad++; $display("FAIL rnd_rden_empty: rden=%b empty=%b", s_rden_a, s_empty_a); end
         if (pv && !pr) begin
            total++; if (s_valid_a !== 1'b1 || s_data_a !== pd) begin bad++; $display("FAIL rnd_stable: got v=%b d=%0h want v=1 d=%0h", s_valid_a, s_data_a, pd); end
         end
         if (s_valid_a && s_ready_a) begin
            total++; if (s_data_a !== {4'h5, 32'(exp_n)}) begin bad++; $display("FAIL rnd_data n=%0d: got %0h want %0h", exp_n, s_data_a, {4'h5, 32'(exp_n)}); end
            exp_n++;
         end
         pv = s_valid_a; pr = s_ready_a; pd = s_data_a;
      end
      total++; if (exp_n != 1000) begin bad++; $display("FAIL rnd_count: got %0d want 1000", exp_n); end
      hold_a = 1'b0;
      mr_a = 1'b1;
      upd_empty();
   endtask

`ifdef FIFO_READER_ERRCNT_EN
   task automatic test_err_count();
      rderr_a = 1'b1;
      repeat (5) cycle();
      rderr_a = 1'b0;
      cycle();
      total++; if (ec_a !== 16'd5) begin bad++; $display("FAIL errcnt_5: got %0d want 5", ec_a); end
      rderr_a = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      rderr_a = 1'b0;
      cycle();
      total++; if (ec_a !== 16'hFFFF) begin bad++; $display("FAIL errcnt_sat: got %0h want ffff", ec_a); end
   endtask
`endif

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      fe_a = 1'b1; fe_b = 1'b1;
      fd_a = '0; fd_b = '0;
      s1_a = '0; s1_b = '0; s2_b = '0;
      mr_a = 1'b0; mr_b = 1'b0;
      rderr_a = 1'b0; rderr_b = 1'b0;
      hold_a = 1'b0; hold_b = 1'b0;
      test_reset();
      test_stream_rl1();
      test_backpressure_rl2();
      test_empty_inflight();
      test_reset_mid();
      test_random();
`ifdef FIFO_READER_ERRCNT_EN
      test_err_count();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
